// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_using_ha.sv
// One-bit full adder built from two half-adder stages.
// Latency: combinational. Backpressure: none.
// Carry-out merges the carries of both half-adder stages.
module fa_using_ha (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ ci;
    assign ha1_c = ha0_s & ci;
    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder, LSB first, one bit per clock.
// Latency: done pulses WIDTH+1 cycles after the cycle start is driven (WIDTH ADD cycles).
// Backpressure: start is ignored while busy; accepted in IDLE and in the DONE cycle.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;

    fa_using_ha u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits enter at the MSB so the LSB computed first ends up in bit 0.
    assign res_next = {fa_s, res[WIDTH-1:1]};
    assign accept   = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
                state <= S_ADD;
                busy  <= 1'b1;
            end else begin
                case (state)
                    S_ADD: begin
                        carry <= fa_co;
                        res   <= res_next;
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST_BIT) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sum   <= res_next;
                            cout  <= fa_co;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: plain (W+1)-bit addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    // Issue one request right after an edge; optionally pulse a rogue start at ADD cycle 'poke'.
    // n_done counts edges from the drive edge to the first sample with done high (0 = never).
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input int poke, output logic [W-1:0] rs, output logic rc,
                          output int n_done, output int busy_n, output bit stable);
        logic [W-1:0] sum0;
        sum0   = sum;
        stable = 1'b1;
        rs     = '0;
        rc     = 1'b0;
        n_done = 0;
        busy_n = 0;
        @(posedge clk); #1;
        start = 1'b1; a = oa; b = ob; cin = oc;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
            end
            if (n == poke) begin
                start = 1'b1; a = '1; b = '1; cin = 1'b1;
            end else if (n == poke + 1) begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                n_done = n;
                rs = sum;
                rc = cout;
                break;
            end
            if (sum !== sum0) stable = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (sum !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_result sum=%h cout=%b expected 00 0", sum, cout);
        end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4] = '{8'h00, 8'hFF, 8'h7F, 8'hA5};
        logic [W-1:0] tb_[4] = '{8'h00, 8'h01, 8'h01, 8'h5A};
        logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [4] = '{8'h00, 8'h00, 8'h80, 8'h00};
        logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] rs;
        logic         rc;
        int           nd, bn;
        bit           st;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb_[i], tc[i], 0, rs, rc, nd, bn, st);
            checks++;
            if (rs !== es[i] || rc !== ec[i]) begin
                failures++;
                $display("FAIL directed_%0d sum=%h cout=%b expected %h %b", i, rs, rc, es[i], ec[i]);
            end
            checks++;
            if (nd != 9 || bn != 8) begin
                failures++;
                $display("FAIL directed_timing_%0d done_at=%0d busy_cycles=%0d expected 9 8", i, nd, bn);
            end
            checks++;
            if (!st) begin
                failures++;
                $display("FAIL directed_hold_%0d sum changed before done", i);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== es[i]) begin
                failures++;
                $display("FAIL directed_after_%0d done=%b busy=%b sum=%h expected 0 0 %h", i, done, busy, sum, es[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [W-1:0] rs;
        logic         rc;
        int           nd, bn;
        bit           st;
        run_op(8'h10, 8'h20, 1'b0, 3, rs, rc, nd, bn, st);
        checks++;
        if (rs !== 8'h30 || rc !== 1'b0 || nd != 9) begin
            failures++;
            $display("FAIL start_ignored sum=%h cout=%b done_at=%0d expected 30 0 9", rs, rc, nd);
        end
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (busy || done) begin
                failures++;
                $display("FAIL start_dropped busy=%b done=%b expected 0 0", busy, done);
                break;
            end
        end
        checks++;
    endtask

    task automatic test_reset_abort;
        logic [W-1:0] rs;
        logic         rc;
        int           nd, bn;
        bit           st;
        bit           seen;
        run_op(8'h12, 8'h34, 1'b1, 0, rs, rc, nd, bn, st);
        checks++;
        if (rs !== 8'h47 || rc !== 1'b0) begin
            failures++;
            $display("FAIL abort_setup sum=%h cout=%b expected 47 0", rs, rc);
        end
        @(posedge clk); #1;
        start = 1'b1; a = 8'hC3; b = 8'h3C; cin = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL abort_state busy=%b sum=%h cout=%b expected 0 00 0", busy, sum, cout);
        end
        seen = 1'b0;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_done activity seen after reset, expected none");
        end
    endtask

    task automatic test_back_to_back;
        int nd;
        int m;
        nd = 0;
        @(posedge clk); #1;
        start = 1'b1; a = 8'h21; b = 8'h13; cin = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (done) begin
                nd = n;
                break;
            end
        end
        checks++;
        if (nd != 9 || sum !== 8'h34) begin
            failures++;
            $display("FAIL b2b_first done_at=%0d sum=%h expected 9 34", nd, sum);
        end
        start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hEE; b = 8'hDD;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h34) begin
            failures++;
            $display("FAIL b2b_accept busy=%b done=%b sum=%h expected 1 0 34", busy, done, sum);
        end
        m = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                m = n;
                break;
            end
        end
        checks++;
        if (m != 9 || sum !== 8'h07 || cout !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second done_at=%0d sum=%h cout=%b expected 9 07 0", m, sum, cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [W-1:0] oa, ob, rs;
        logic         oc, rc;
        logic [W:0]   exp_r;
        int           nd, bn, poke;
        bit           st;
        for (int i = 0; i < 40; i++) begin
            oa = W'($urandom);
            ob = W'($urandom);
            oc = 1'($urandom);
            poke = $urandom_range(0, 8);
            exp_r = ref_add(oa, ob, oc);
            run_op(oa, ob, oc, poke, rs, rc, nd, bn, st);
            checks++;
            if ({rc, rs} !== exp_r || nd != 9 || bn != 8 || !st) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h cin=%b got cout=%b sum=%h done_at=%0d busy=%0d stable=%0d expected %b %h 9 8 1",
                         i, oa, ob, oc, rc, rs, nd, bn, st, exp_r[W], exp_r[W-1:0]);
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
